// File: rtl/write_if.sv
// DRAM write-path bus: request/address/data inputs and DDR command/data pins.
// master drives the request side, slave (the write engine) drives the pins.
interface write_if;
    logic        in;
    logic        in_p;
    logic [14:0] Addr_Row;
    logic [9:0]  Addr_Column;
    logic        Addr_Column_11;
    logic        A_10;
    logic        A_12;
    logic [3:0]  BA_in;
    logic [15:0] DQ_in;
    logic        CS_n;
    logic        RAS_n;
    logic        CAS_n;
    logic        WE_n;
    logic [14:0] Addr_out;
    logic [2:0]  BA_out;
    logic        LDM;
    logic        UDM;
    logic [15:0] DQ_out;
    logic        UDQS;
    logic        LDQS;

    modport master (
        output in, in_p, Addr_Row, Addr_Column, Addr_Column_11,
        output A_10, A_12, BA_in, DQ_in,
        input  CS_n, RAS_n, CAS_n, WE_n, Addr_out, BA_out,
        input  LDM, UDM, DQ_out, UDQS, LDQS
    );

    modport slave (
        input  in, in_p, Addr_Row, Addr_Column, Addr_Column_11,
        input  A_10, A_12, BA_in, DQ_in,
        output CS_n, RAS_n, CAS_n, WE_n, Addr_out, BA_out,
        output LDM, UDM, DQ_out, UDQS, LDQS
    );
endinterface

// File: rtl/write.sv
// DDR write engine: ACTIVATE, WRITE, data burst, optional PRECHARGE.
// Ports: clk, areset (async, active-high), bus (write_if.slave).
module write #(
    parameter int TRCD = 3,
    parameter int CWL  = 5,
    parameter int TWR  = 4
) (
    input logic   clk,
    input logic   areset,
    write_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ACT, RCD, WR, CWLW, BURST, WRR, PRE
    } state_t;

    localparam int M1   = (TRCD > CWL) ? TRCD : CWL;
    localparam int M2   = (M1 > TWR) ? M1 : TWR;
    localparam int MAXC = (M2 > 8) ? M2 : 8;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] RCD_END = CW'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [CW-1:0] CWL_END = CW'(CWL - 2);
    localparam logic [CW-1:0] WRR_END = CW'(TWR - 1);
    localparam logic [CW-1:0] BL8_END = CW'(7);
    localparam logic [CW-1:0] BC4_END = CW'(3);

    state_t        state, state_n;
    logic [CW-1:0] cnt;

    logic [14:0] row_q;
    logic [9:0]  col_q;
    logic        c11_q;
    logic        a10_q;
    logic        a12_q;
    logic [2:0]  ba_q;
    logic        inp_q;

    logic unused_ba3;
    assign unused_ba3 = bus.BA_in[3];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counter restarts at zero on every state change and saturates.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            row_q <= '0;
            col_q <= '0;
            c11_q <= 1'b0;
            a10_q <= 1'b0;
            a12_q <= 1'b0;
            ba_q  <= '0;
            inp_q <= 1'b0;
        end else if (state == IDLE && bus.in) begin
            row_q <= bus.Addr_Row;
            col_q <= bus.Addr_Column;
            c11_q <= bus.Addr_Column_11;
            a10_q <= bus.A_10;
            a12_q <= bus.A_12;
            ba_q  <= bus.BA_in[2:0];
            inp_q <= bus.in_p;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (bus.in) state_n = ACT;
            // With TRCD of 1 there is no NOP gap before WRITE.
            ACT:   state_n = (TRCD > 1) ? RCD : WR;
            RCD:   if (cnt == RCD_END) state_n = WR;
            WR:    state_n = CWLW;
            CWLW:  if (cnt == CWL_END) state_n = BURST;
            BURST: if (cnt == (a12_q ? BL8_END : BC4_END)) state_n = WRR;
            WRR:   if (cnt == WRR_END) state_n = inp_q ? IDLE : PRE;
            PRE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.CS_n     = 1'b0;
        bus.RAS_n    = 1'b1;
        bus.CAS_n    = 1'b1;
        bus.WE_n     = 1'b1;
        bus.Addr_out = '0;
        bus.BA_out   = '0;
        bus.DQ_out   = '0;
        bus.LDM      = 1'b1;
        bus.UDM      = 1'b1;
        bus.UDQS     = 1'b0;
        bus.LDQS     = 1'b0;
        unique case (state)
            ACT: begin
                bus.RAS_n    = 1'b0;
                bus.Addr_out = row_q;
                bus.BA_out   = ba_q;
            end
            WR: begin
                bus.CAS_n    = 1'b0;
                bus.WE_n     = 1'b0;
                bus.BA_out   = ba_q;
                bus.Addr_out = {2'b00, a12_q, c11_q, inp_q, col_q};
            end
            BURST: begin
                bus.DQ_out = bus.DQ_in;
                bus.LDM    = 1'b0;
                bus.UDM    = 1'b0;
                // Strobe toggles once per beat, high on even beats.
                bus.UDQS   = ~cnt[0];
                bus.LDQS   = ~cnt[0];
            end
            PRE: begin
                bus.RAS_n    = 1'b0;
                bus.WE_n     = 1'b0;
                bus.BA_out   = ba_q;
                bus.Addr_out = {4'b0000, a10_q, 10'b0};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_write.sv
// Directed scoreboard bench for the DDR write engine.
// Per-cycle expected pin values are queued, then popped and compared.
module tb_write;
    localparam int TRCD = 3;
    localparam int CWL  = 5;
    localparam int TWR  = 4;

    localparam logic [3:0] NOPC = 4'b0111;
    localparam logic [3:0] ACTC = 4'b0011;
    localparam logic [3:0] WRC  = 4'b0100;
    localparam logic [3:0] PREC = 4'b0010;

    typedef struct packed {
        logic [14:0] row;
        logic [9:0]  col;
        logic        c11;
        logic        a10;
        logic        a12;
        logic [3:0]  ba;
        logic        inp;
        logic [15:0] dq0;
        logic [15:0] dstep;
    } cfg_t;

    typedef struct packed {
        logic [47:0] tag;
        logic [41:0] exp;
        logic [15:0] drv;
        logic        in_next;
    } ent_t;

    logic clk;
    logic areset;
    int   checks;
    int   failures;
    bit   scramble;
    ent_t q[$];

    write_if bus ();

    write #(.TRCD(TRCD), .CWL(CWL), .TWR(TWR)) u_dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [41:0] obs();
        return {bus.CS_n, bus.RAS_n, bus.CAS_n, bus.WE_n,
                bus.Addr_out, bus.BA_out, bus.LDM, bus.UDM,
                bus.UDQS, bus.LDQS, bus.DQ_out};
    endfunction

    function automatic ent_t mk(input logic [47:0] tag,
                                input logic [3:0] cmd,
                                input logic [14:0] addr,
                                input logic [2:0] ba,
                                input logic [1:0] dm,
                                input logic [1:0] dqs,
                                input logic [15:0] dq,
                                input logic [15:0] drv);
        ent_t e;
        e.tag     = tag;
        e.exp     = {cmd, addr, ba, dm, dqs, dq};
        e.drv     = drv;
        e.in_next = 1'b0;
        return e;
    endfunction

    function automatic ent_t nop(input logic [47:0] tag);
        return mk(tag, NOPC, '0, '0, 2'b11, 2'b00, '0, 16'($urandom));
    endfunction

    task automatic chk(input logic [47:0] tag, input logic [41:0] exp);
        logic [41:0] o;
        o = obs();
        checks++;
        assert (o === exp) else begin
            failures++;
            $error("FAIL %0s t=%0t got=%h exp=%h", tag, $time, o, exp);
        end
    endtask

    task automatic apply(input cfg_t c);
        bus.Addr_Row       = c.row;
        bus.Addr_Column    = c.col;
        bus.Addr_Column_11 = c.c11;
        bus.A_10           = c.a10;
        bus.A_12           = c.a12;
        bus.BA_in          = c.ba;
        bus.in_p           = c.inp;
    endtask

    // nb < 0: full transaction; otherwise stop after nb data beats.
    task automatic gen_txn(input cfg_t c, input int nb);
        int blen;
        int n;
        logic [15:0] d;
        q.push_back(mk("ACT", ACTC, c.row, c.ba[2:0], 2'b11, 2'b00,
                       '0, 16'($urandom)));
        for (int i = 0; i < TRCD - 1; i++) q.push_back(nop("RCD"));
        q.push_back(mk("WR", WRC, {2'b00, c.a12, c.c11, c.inp, c.col},
                       c.ba[2:0], 2'b11, 2'b00, '0, 16'($urandom)));
        for (int i = 0; i < CWL - 1; i++) q.push_back(nop("CWL"));
        blen = c.a12 ? 8 : 4;
        n = (nb < 0) ? blen : nb;
        for (int b = 0; b < n; b++) begin
            d = c.dq0 + 16'(b) * c.dstep;
            q.push_back(mk("BEAT", NOPC, '0, '0, 2'b00,
                           (b % 2 == 0) ? 2'b11 : 2'b00, d, d));
        end
        if (nb < 0) begin
            for (int i = 0; i < TWR; i++) q.push_back(nop("WRR"));
            if (!c.inp)
                q.push_back(mk("PRE", PREC, {4'b0, c.a10, 10'b0},
                               c.ba[2:0], 2'b11, 2'b00, '0,
                               16'($urandom)));
        end
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) q.push_back(nop("IDLE"));
    endtask

    task automatic run();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            bus.DQ_in = e.drv;
            #1;
            chk(e.tag, e.exp);
            bus.in = e.in_next;
            if (scramble && !e.in_next) begin
                bus.Addr_Row    = 15'($urandom);
                bus.Addr_Column = 10'($urandom);
                bus.BA_in       = 4'($urandom);
                bus.A_12        = 1'($urandom);
                bus.in_p        = 1'($urandom);
            end
        end
    endtask

    localparam logic [41:0] DEF = {NOPC, 15'h0, 3'h0, 2'b11, 2'b00, 16'h0};

    cfg_t c1, c2, c3;
    int   n1;

    initial begin
        checks   = 0;
        failures = 0;
        scramble = 1'b0;
        areset   = 1'b1;
        bus.in   = 1'b0;
        bus.DQ_in = 16'hDEAD;
        c1 = '{row: 15'h1A2B, col: 10'h3C4, c11: 1'b1, a10: 1'b0,
               a12: 1'b0, ba: 4'h3, inp: 1'b1,
               dq0: 16'hF00F, dstep: 16'h0};
        c2 = '{row: 15'h7001, col: 10'h155, c11: 1'b0, a10: 1'b1,
               a12: 1'b1, ba: 4'h2, inp: 1'b0,
               dq0: 16'h1234, dstep: 16'h0101};
        c3 = '{row: 15'h0F0F, col: 10'h2AA, c11: 1'b0, a10: 1'b0,
               a12: 1'b0, ba: 4'hA, inp: 1'b0,
               dq0: 16'hBEEF, dstep: 16'h0011};
        apply(c1);
        #2;
        chk("RST0", DEF);
        @(posedge clk);
        #2;
        chk("RST1", DEF);
        @(negedge clk);
        areset = 1'b0;

        // Auto-precharge BC4 with inputs scrambled after capture.
        scramble = 1'b1;
        apply(c1);
        bus.in = 1'b1;
        gen_txn(c1, -1);
        idles(3);
        run();
        scramble = 1'b0;

        // Explicit precharge BL8.
        apply(c2);
        bus.in = 1'b1;
        gen_txn(c2, -1);
        idles(2);
        run();

        // Request held high for two clocks gives one transaction.
        apply(c1);
        bus.in = 1'b1;
        gen_txn(c1, -1);
        q[0].in_next = 1'b1;
        idles(4);
        run();

        // Back-to-back with in held high; bank bit 3 ignored.
        apply(c3);
        bus.in = 1'b1;
        gen_txn(c3, -1);
        idles(1);
        n1 = q.size();
        for (int i = 0; i < n1; i++) q[i].in_next = 1'b1;
        gen_txn(c3, -1);
        idles(2);
        run();

        // Reset during the burst aborts without PRE.
        apply(c2);
        bus.in = 1'b1;
        gen_txn(c2, 2);
        run();
        areset = 1'b1;
        #1;
        chk("ARST", DEF);
        @(posedge clk);
        #2;
        chk("ARSTH", DEF);
        @(negedge clk);
        areset = 1'b0;
        idles(TWR + 6);
        run();

        // Recovery after the abort.
        apply(c1);
        bus.in = 1'b1;
        gen_txn(c1, -1);
        idles(2);
        run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/write.md
WRITE -- requirements
Module: write

Interface
REQ-001 Parameter TRCD, default 3, ACTIVATE-to-WRITE spacing in clocks (legal range 1 or more).
REQ-002 Parameter CWL, default 5, WRITE-to-first-data-beat spacing in clocks (legal range 2 or more).
REQ-003 Parameter TWR, default 4, last-data-beat-to-precharge spacing in clocks (legal range 1 or more).
REQ-004 Ports: clk in 1, sole clock, rising edge; areset in 1, reset, asynchronous, active-high.
REQ-005 Ports: in in 1, write request; in_p in 1, auto-precharge select.
REQ-006 Ports: Addr_Row in 15, row address; Addr_Column in 10, column A[9:0]; Addr_Column_11 in 1, column A11.
REQ-007 Ports: A_10 in 1, precharge-all select for explicit PRECHARGE; A_12 in 1, burst length select (1 = BL8, 0 = BC4).
REQ-008 Ports: BA_in in 4, bank address (bit 3 ignored); DQ_in in 16, write data.
REQ-009 Ports: CS_n, RAS_n, CAS_n, WE_n out 1 each, DRAM command pins.
REQ-010 Ports: Addr_out out 15, DRAM address; BA_out out 3, DRAM bank.
REQ-011 Ports: LDM, UDM out 1 each, byte data masks; DQ_out out 16, data; UDQS, LDQS out 1 each, strobes.

Function
REQ-012 The block SHALL be a single FSM with states IDLE, ACT, RCD, WR, CWLW, BURST, WRR, PRE; outputs decoded from state plus latched registers.
REQ-013 IDLE: on a rising clk edge with in=1, capture Addr_Row, Addr_Column, Addr_Column_11, A_10, A_12, BA_in[2:0], in_p into holding registers, then go to ACT; otherwise stay in IDLE.
REQ-014 in is level-sensitive and sampled only in IDLE; its value in all other states is ignored.
REQ-015 Inputs other than DQ_in are used only from the holding registers after capture.
REQ-016 Default outputs in every state unless overridden:
  - CS_n=0, RAS_n=1, CAS_n=1, WE_n=1 (NOP)
  - Addr_out=0, BA_out=0, DQ_out=0
  - LDM=UDM=1, UDQS=LDQS=0
REQ-017 ACT (1 clk): RAS_n=0, Addr_out=row, BA_out=bank; next state is RCD.
REQ-018 RCD (TRCD-1 clks, NOP): next state is WR.
REQ-019 WR (1 clk): RAS_n=1, CAS_n=0, WE_n=0, BA_out=bank; Addr_out bit mapping:
  - [9:0] = column
  - [10] = latched in_p
  - [11] = Addr_Column_11
  - [12] = A_12
  - [14:13] = 0
  Next state is CWLW.
REQ-020 CWLW (CWL-1 clks, NOP): UDQS=LDQS=0 (preamble); next state is BURST.
REQ-021 BURST lasts 8 clks if latched A_12=1, else 4 clks. Each beat:
  - DQ_out = current DQ_in
  - LDM=UDM=0
  - UDQS=LDQS=1 on even beats (0,2,...), 0 on odd beats
  Next state is WRR.
REQ-022 WRR (TWR clks, NOP): next state is PRE if latched in_p=0, else IDLE.
REQ-023 PRE (1 clk): RAS_n=0, WE_n=0, Addr_out[10]=latched A_10, BA_out=bank, other Addr_out bits 0; next state is IDLE.
REQ-024 Cycle and beat counters SHALL be sized for the parameters; they clear on every state entry and never wrap within a state.
REQ-025 A new request SHALL require at least one clock in IDLE between transactions.

Reset
REQ-026 areset=1 SHALL force IDLE, clear the holding registers and counters immediately (asynchronously, without waiting for a clk edge), and drive the REQ-016 defaults.
REQ-027 Assertion of areset mid-transaction SHALL abort it with no further commands; after release the block waits in IDLE for in.
REQ-028 areset has priority over all other inputs.

Verification
REQ-029 Reset: areset=1 -> CS_n=0, RAS_n/CAS_n/WE_n=1, Addr_out=0, DQ_out=0, LDM=UDM=1, strobes 0.
REQ-030 Auto-precharge BC4: in=1, in_p=1, Addr_Row=15'h1A2B, Addr_Column=10'h3C4, Addr_Column_11=1, A_12=0, BA_in=4'h3, DQ_in=16'hF00F (defaults) -> expected sequence:
  - ACT: Addr_out=15'h1A2B, BA_out=3
  - 2 NOP clks, then WR: Addr_out=15'h0FC4
  - 4 NOP clks, then 4 beats of DQ_out=16'hF00F with strobes 1,0,1,0
  - 4 NOP clks, then IDLE with no PRE
REQ-031 Explicit precharge BL8: in_p=0, A_12=1, A_10=1, BA_in=4'h2 -> expected:
  - WR with Addr_out[12]=1, Addr_out[10]=0
  - 8 data beats
  - PRE with Addr_out=15'h0400, BA_out=2
REQ-032 Request held high: in held at 1 for 2 clks -> exactly one transaction.
REQ-033 Back-to-back: in kept at 1 through the end of a transaction -> second ACT follows exactly one clk after return to IDLE.
REQ-034 Mid-burst reset: areset pulsed during BURST -> outputs return to defaults immediately, no PRE issued.
